// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: tracks EX/MEM/WB register tags
// and drives stall, flush and operand-forwarding controls combinationally.
module hazard_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            id_valid_i,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic            id_rs1_used_i,
  input  logic            id_rs2_used_i,
  input  logic [4:0]      id_rd_addr_i,
  input  logic            id_rd_wren_i,
  input  logic            id_is_load_i,
  input  logic            ex_br_taken_i,
  input  logic            mem_busy_i,
  output logic            stall_pc_o,
  output logic            stall_ifid_o,
  output logic            stall_idex_o,
  output logic            flush_ifid_o,
  output logic            flush_idex_o,
  output logic [1:0]      fwd_a_sel_o,
  output logic [1:0]      fwd_b_sel_o,
  output logic            fwd_id_rs1_o,
  output logic            fwd_id_rs2_o,
  output logic [XLEN-1:0] stall_cnt_o,
  output logic [XLEN-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH, FREEZE} state_t;

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  state_t state_reg, resume_reg;

  logic       sh_valid    [3];
  logic [4:0] sh_rd       [3];
  logic       sh_wren     [3];
  logic       sh_load     [3];
  logic [4:0] sh_rs1      [3];
  logic [4:0] sh_rs2      [3];
  logic       sh_rs1_used [3];
  logic       sh_rs2_used [3];
  logic       live        [3];

  logic [XLEN-1:0] stall_cnt_reg, flush_cnt_reg;

  logic [4:0] ex_src  [2];
  logic       ex_used [2];
  logic [4:0] id_src  [2];
  logic       id_used [2];
  logic [1:0] fwd_sel [2];
  logic       fwd_id  [2];
  logic       ld_hit  [2];

  logic freeze, branch, load_use, take_id;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_live
      assign live[gi] = sh_valid[gi] & sh_wren[gi] & (sh_rd[gi] != 5'd0);
    end
  endgenerate

  assign ex_src[0]  = sh_rs1[EX];
  assign ex_src[1]  = sh_rs2[EX];
  assign ex_used[0] = sh_valid[EX] & sh_rs1_used[EX];
  assign ex_used[1] = sh_valid[EX] & sh_rs2_used[EX];
  assign id_src[0]  = id_rs1_addr_i;
  assign id_src[1]  = id_rs2_addr_i;
  assign id_used[0] = id_rs1_used_i;
  assign id_used[1] = id_rs2_used_i;

  // Index 0 is operand a / rs1, index 1 is operand b / rs2.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_sel[gi] =
        !ex_used[gi] ? 2'b00 :
        (live[MEM] && !sh_load[MEM] && sh_rd[MEM] == ex_src[gi]) ? 2'b01 :
        (live[WB] && sh_rd[WB] == ex_src[gi]) ? 2'b10 : 2'b00;
      assign fwd_id[gi] = live[WB] & id_used[gi] & (sh_rd[WB] == id_src[gi]);
      assign ld_hit[gi] = id_used[gi] & (sh_rd[EX] == id_src[gi]);
    end
  endgenerate

  // Freeze dominates, then a taken branch, then a load-use bubble.
  assign freeze   = mem_busy_i;
  assign branch   = ex_br_taken_i & ~mem_busy_i;
  assign load_use = id_valid_i & live[EX] & sh_load[EX] & (ld_hit[0] | ld_hit[1])
                    & ~ex_br_taken_i & ~mem_busy_i;
  assign take_id  = id_valid_i & ~branch & ~load_use;

  assign stall_pc_o   = freeze | load_use;
  assign stall_ifid_o = freeze | load_use;
  assign stall_idex_o = freeze;
  assign flush_ifid_o = branch;
  assign flush_idex_o = branch | load_use;
  assign fwd_a_sel_o  = fwd_sel[0];
  assign fwd_b_sel_o  = fwd_sel[1];
  assign fwd_id_rs1_o = fwd_id[0];
  assign fwd_id_rs2_o = fwd_id[1];
  assign stall_cnt_o  = stall_cnt_reg;
  assign flush_cnt_o  = flush_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 3; i++) begin
        sh_valid[i]    <= 1'b0;
        sh_rd[i]       <= 5'd0;
        sh_wren[i]     <= 1'b0;
        sh_load[i]     <= 1'b0;
        sh_rs1[i]      <= 5'd0;
        sh_rs2[i]      <= 5'd0;
        sh_rs1_used[i] <= 1'b0;
        sh_rs2_used[i] <= 1'b0;
      end
    end else if (!freeze) begin
      for (int i = 1; i < 3; i++) begin
        sh_valid[i]    <= sh_valid[i-1];
        sh_rd[i]       <= sh_rd[i-1];
        sh_wren[i]     <= sh_wren[i-1];
        sh_load[i]     <= sh_load[i-1];
        sh_rs1[i]      <= sh_rs1[i-1];
        sh_rs2[i]      <= sh_rs2[i-1];
        sh_rs1_used[i] <= sh_rs1_used[i-1];
        sh_rs2_used[i] <= sh_rs2_used[i-1];
      end
      sh_valid[EX]    <= take_id;
      sh_rd[EX]       <= take_id ? id_rd_addr_i  : 5'd0;
      sh_wren[EX]     <= take_id & id_rd_wren_i;
      sh_load[EX]     <= take_id & id_is_load_i;
      sh_rs1[EX]      <= take_id ? id_rs1_addr_i : 5'd0;
      sh_rs2[EX]      <= take_id ? id_rs2_addr_i : 5'd0;
      sh_rs1_used[EX] <= take_id & id_rs1_used_i;
      sh_rs2_used[EX] <= take_id & id_rs2_used_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
      state_reg     <= RUN;
      resume_reg    <= RUN;
    end else begin
      if (load_use) stall_cnt_reg <= stall_cnt_reg + {{(XLEN-1){1'b0}}, 1'b1};
      if (branch)   flush_cnt_reg <= flush_cnt_reg + {{(XLEN-1){1'b0}}, 1'b1};
      if (freeze) begin
        state_reg <= FREEZE;
        if (state_reg != FREEZE) resume_reg <= state_reg;
      end else if (branch) begin
        state_reg <= FLUSH;
      end else if (load_use) begin
        state_reg <= LDSTALL;
      end else if (state_reg == FREEZE) begin
        state_reg <= resume_reg;
      end else begin
        state_reg <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl: one row per cycle with
// hand-computed control, forwarding and counter expectations.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  rs1, rs2, rd;
  logic        u1, u2, wren, load, br, busy;
  logic        stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex;
  logic [1:0]  fwd_a, fwd_b;
  logic        fwd_id1, fwd_id2;
  logic [31:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2),
    .id_rd_addr_i(rd), .id_rd_wren_i(wren), .id_is_load_i(load),
    .ex_br_taken_i(br), .mem_busy_i(busy),
    .stall_pc_o(stall_pc), .stall_ifid_o(stall_ifid), .stall_idex_o(stall_idex),
    .flush_ifid_o(flush_ifid), .flush_idex_o(flush_idex),
    .fwd_a_sel_o(fwd_a), .fwd_b_sel_o(fwd_b),
    .fwd_id_rs1_o(fwd_id1), .fwd_id_rs2_o(fwd_id2),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       wr, ld, br, busy;
    logic [4:0] ctl;   // {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex}
    logic [5:0] fwd;   // {fwd_a, fwd_b, fwd_id1, fwd_id2}
    int         sc, fc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [4:0] a, input logic [4:0] b,
                              input logic ua, input logic ub, input logic [4:0] d,
                              input logic w, input logic l, input logic t, input logic y,
                              input logic [4:0] c, input logic [5:0] f,
                              input int s, input int fl);
    vec_t r;
    r.v = v; r.rs1 = a; r.rs2 = b; r.u1 = ua; r.u2 = ub; r.rd = d;
    r.wr = w; r.ld = l; r.br = t; r.busy = y; r.ctl = c; r.fwd = f; r.sc = s; r.fc = fl;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    id_valid = r.v; rs1 = r.rs1; rs2 = r.rs2; u1 = r.u1; u2 = r.u2;
    rd = r.rd; wren = r.wr; load = r.ld; br = r.br; busy = r.busy;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h want %0h", nm, idx, got, want);
    end
  endtask

  task automatic chk_all(input int idx, input logic [4:0] ctl, input logic [5:0] fwd,
                         input int sc, input int fc);
    chk("ctl", idx, {27'd0, stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex}, {27'd0, ctl});
    chk("fwd", idx, {26'd0, fwd_a, fwd_b, fwd_id1, fwd_id2}, {26'd0, fwd});
    chk("stall_cnt", idx, stall_cnt, sc);
    chk("flush_cnt", idx, flush_cnt, fc);
    $display("row %0d: ctl=%b fwd=%b stall_cnt=%0d flush_cnt=%0d", idx,
             {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex},
             {fwd_a, fwd_b, fwd_id1, fwd_id2}, stall_cnt, flush_cnt);
  endtask

  vec_t nop;

  initial begin
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 6'b0, 0, 0);
    //            v rs1 rs2 u1 u2 rd wr ld br busy ctl       fwd        sc fc
    tbl.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 5'b00000, 6'b000000, 0, 0)); // lw x5
    tbl.push_back(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 5'b11001, 6'b000000, 0, 0)); // add x6,x5,x7
    tbl.push_back(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 5'b00000, 6'b000000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 6'b100000, 1, 0));
    tbl.push_back(mk(1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 5'b00000, 6'b000000, 1, 0)); // add x1
    tbl.push_back(mk(1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 5'b00000, 6'b000000, 1, 0)); // sub x2,x1,x1
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 6'b010100, 1, 0));
    tbl.push_back(mk(1, 4, 4, 1, 1, 3, 1, 0, 0, 0, 5'b00000, 6'b000000, 1, 0)); // add x3
    tbl.push_back(mk(1, 9, 9, 1, 1, 8, 1, 0, 0, 0, 5'b00000, 6'b000000, 1, 0)); // and x8
    tbl.push_back(mk(1, 3, 3, 1, 1, 10, 1, 0, 0, 0, 5'b00000, 6'b000000, 1, 0)); // sub x10,x3,x3
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 6'b101000, 1, 0));
    tbl.push_back(mk(1, 8, 0, 1, 1, 11, 1, 0, 0, 0, 5'b00000, 6'b000010, 1, 0)); // ID bypass x8
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 5'b00000, 6'b000000, 1, 0)); // write x0
    tbl.push_back(mk(1, 0, 0, 1, 1, 12, 1, 0, 0, 0, 5'b00000, 6'b000000, 1, 0)); // read x0
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 6'b000000, 1, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 5'b00000, 6'b000000, 1, 0)); // lw x5
    tbl.push_back(mk(1, 5, 5, 0, 0, 5, 1, 0, 0, 0, 5'b00000, 6'b000000, 1, 0)); // lui x5
    tbl.push_back(mk(1, 5, 5, 1, 1, 13, 1, 0, 0, 0, 5'b00000, 6'b000000, 1, 0)); // add x13,x5,x5
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 6'b010100, 1, 0));
    tbl.push_back(mk(1, 2, 0, 1, 0, 7, 1, 1, 0, 0, 5'b00000, 6'b000000, 1, 0)); // lw x7
    tbl.push_back(mk(1, 7, 7, 1, 1, 14, 1, 0, 1, 0, 5'b00011, 6'b000000, 1, 0)); // branch over load-use
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 6'b000000, 1, 1));
    tbl.push_back(mk(1, 1, 0, 1, 0, 9, 1, 1, 0, 0, 5'b00000, 6'b000000, 1, 1)); // lw x9
    tbl.push_back(mk(1, 9, 0, 1, 1, 15, 1, 0, 0, 1, 5'b11100, 6'b000000, 1, 1)); // frozen x3
    tbl.push_back(mk(1, 9, 0, 1, 1, 15, 1, 0, 0, 1, 5'b11100, 6'b000000, 1, 1));
    tbl.push_back(mk(1, 9, 0, 1, 1, 15, 1, 0, 0, 1, 5'b11100, 6'b000000, 1, 1));
    tbl.push_back(mk(1, 9, 0, 1, 1, 15, 1, 0, 0, 0, 5'b11001, 6'b000000, 1, 1)); // released
    tbl.push_back(mk(1, 9, 0, 1, 1, 15, 1, 0, 0, 0, 5'b00000, 6'b000000, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 6'b100000, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11100, 6'b000000, 2, 1)); // freeze over branch
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00011, 6'b000000, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 6'b000000, 2, 2));

    // Reset for two cycles with random inputs.
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      id_valid = 1'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      u1 = 1'($urandom); u2 = 1'($urandom); rd = 5'($urandom);
      wren = 1'($urandom); load = 1'($urandom); br = 1'($urandom); busy = 1'($urandom);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    drive(nop);
    @(negedge clk);
    chk_all(-1, 5'b00000, 6'b000000, 0, 0);

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      @(negedge clk);
      chk_all(i, tbl[i].ctl, tbl[i].fwd, tbl[i].sc, tbl[i].fc);
    end

    // Reset arriving mid load-use and freeze must leave an empty shadow and zero counters.
    @(posedge clk); #1;
    drive(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 5'b0, 6'b0, 0, 0));
    @(posedge clk); #1;
    drive(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 5'b0, 6'b0, 0, 0));
    @(negedge clk);
    chk_all(100, 5'b11001, 6'b000000, 2, 2);
    busy = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 5'b0, 6'b0, 0, 0));
    @(negedge clk);
    chk_all(101, 5'b00000, 6'b000000, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
